// File: rtl/uart_rx_engine_if.sv
// Host-side bundle for the UART receive engine: line input, frame
// configuration, read strobe and the received character with its status flags.
interface uart_rx_engine_if;
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       RX;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    modport master (
        output baud, eight, pen, ohel, RX, rx_read,
        input  rx_data, rxrdy, perr, ferr, ovf
    );

    modport slave (
        input  baud, eight, pen, ohel, RX, rx_read,
        output rx_data, rxrdy, perr, ferr, ovf
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes RX, frames start/data/parity/stop bits using a
// mid-bit sampling counter, and presents the character with parity, framing
// and overrun status until the host reads it.
module uart_rx_engine #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_engine_if.slave   bus
);
    // Bit times in clocks, rounded to nearest, for each supported rate.
    localparam int unsigned BT_0 = (CLK_HZ + 150) / 300;
    localparam int unsigned BT_1 = (CLK_HZ + 600) / 1200;
    localparam int unsigned BT_2 = (CLK_HZ + 1200) / 2400;
    localparam int unsigned BT_3 = (CLK_HZ + 2400) / 4800;
    localparam int unsigned BT_4 = (CLK_HZ + 4800) / 9600;
    localparam int unsigned BT_5 = (CLK_HZ + 9600) / 19200;
    localparam int unsigned BT_6 = (CLK_HZ + 19200) / 38400;
    localparam int unsigned BT_7 = (CLK_HZ + 28800) / 57600;
    localparam int unsigned BT_8 = (CLK_HZ + 57600) / 115200;
    localparam int unsigned BT_9 = (CLK_HZ + 115200) / 230400;
    localparam int unsigned BT_A = (CLK_HZ + 230400) / 460800;
    localparam int unsigned BT_B = (CLK_HZ + 460800) / 921600;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic        par_q, par_d;
    logic [18:0] bt_q, bt_d;
    logic        eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
    logic        rx_s1, rx_s2;
    logic [18:0] bt_sel;
    logic        expire, last_bit, done, stop_bad, perr_new;
    logic [7:0]  data_q;
    logic        rxrdy_q, perr_q, ferr_q, ovf_q;

    // Decode the baud select code into a bit time.
    always_comb begin
        case (bus.baud)
            4'h0:    bt_sel = 19'(BT_0);
            4'h1:    bt_sel = 19'(BT_1);
            4'h2:    bt_sel = 19'(BT_2);
            4'h3:    bt_sel = 19'(BT_3);
            4'h4:    bt_sel = 19'(BT_4);
            4'h5:    bt_sel = 19'(BT_5);
            4'h6:    bt_sel = 19'(BT_6);
            4'h7:    bt_sel = 19'(BT_7);
            4'h8:    bt_sel = 19'(BT_8);
            4'h9:    bt_sel = 19'(BT_9);
            4'hA:    bt_sel = 19'(BT_A);
            4'hB:    bt_sel = 19'(BT_B);
            default: bt_sel = 19'(BT_0);
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= bus.RX;
            rx_s2 <= rx_s1;
        end
    end

    // Frame state, bit timer, data shifter and per-frame configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            bt_q    <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            bt_q    <= bt_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            ohel_q  <= ohel_d;
        end
    end

    // Next-state logic: half-bit wait into START, then one sample per bit time.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        par_d    = par_q;
        bt_d     = bt_q;
        eight_d  = eight_q;
        pen_d    = pen_q;
        ohel_d   = ohel_q;
        done     = 1'b0;
        stop_bad = 1'b0;
        expire   = (cnt_q <= 19'd1);
        last_bit = eight_q ? (idx_q == 4'd7) : (idx_q == 4'd6);
        case (state_q)
            IDLE: begin
                if (!rx_s2) begin
                    state_d = START;
                    bt_d    = bt_sel;
                    cnt_d   = bt_sel >> 1;
                    eight_d = bus.eight;
                    pen_d   = bus.pen;
                    ohel_d  = bus.ohel;
                    idx_d   = '0;
                    sh_d    = '0;
                    par_d   = 1'b0;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - 19'd1;
                end else if (!rx_s2) begin
                    state_d = DATA;
                    cnt_d   = bt_q;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - 19'd1;
                end else begin
                    sh_d[idx_q[2:0]] = rx_s2;
                    idx_d = idx_q + 4'd1;
                    cnt_d = bt_q;
                    if (last_bit) state_d = pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (!expire) begin
                    cnt_d = cnt_q - 19'd1;
                end else begin
                    par_d   = rx_s2;
                    cnt_d   = bt_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - 19'd1;
                end else begin
                    done     = 1'b1;
                    stop_bad = !rx_s2;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign perr_new = pen_q & ((^sh_q ^ par_q) != ohel_q);

    // Host-visible character and status; a completing frame takes priority over a read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            rxrdy_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (done) begin
            data_q  <= sh_q;
            perr_q  <= perr_new;
            ferr_q  <= stop_bad;
            rxrdy_q <= 1'b1;
            ovf_q   <= rxrdy_q & ~bus.rx_read;
        end else if (bus.rx_read) begin
            rxrdy_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end
    end

    assign bus.rx_data = data_q;
    assign bus.rxrdy   = rxrdy_q;
    assign bus.perr    = perr_q;
    assign bus.ferr    = ferr_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: directed frames for the documented scenarios plus
// randomized frames, checked every cycle against a frame-level status model.
module tb_uart_rx_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_engine_if bus ();

    uart_rx_engine #(.CLK_HZ(100000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of host-visible state after each whole frame / read / reset.
    logic [7:0] m_data  = 8'h00;
    logic       m_rxrdy = 1'b0;
    logic       m_perr  = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovf   = 1'b0;
    bit         settling = 1'b0;
    bit         live     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs compared with the model on every cycle outside the stop-bit window.
    always @(negedge clk) begin
        if (live && !settling)
            chk("cycle", {20'd0, bus.rx_data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf},
                {20'd0, m_data, m_rxrdy, m_perr, m_ferr, m_ovf});
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pop(input logic [7:0] d);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(d[i]);
        return c;
    endfunction

    task automatic do_read();
        bus.rx_read = 1'b1;
        hold(1);
        bus.rx_read = 1'b0;
        m_rxrdy = 1'b0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic e8, input logic p_en, input logic odd,
                        input logic [3:0] bcode, input bit bad_par, input logic stopv,
                        input bit coinc, input bit scramble, input int abort_bit);
        int         bt;
        int         nb;
        logic [7:0] dm;
        logic       pb;
        bt = (bcode == 4'hA) ? 217 : 109;
        nb = e8 ? 8 : 7;
        dm = e8 ? d : {1'b0, d[6:0]};
        pb = logic'(pop(dm) % 2) ^ odd ^ logic'(bad_par);
        bus.baud  = bcode;
        bus.eight = e8;
        bus.pen   = p_en;
        bus.ohel  = odd;
        bus.RX    = 1'b0;
        hold(bt);
        for (int k = 0; k < nb; k++) begin
            if (k == abort_bit) begin
                bus.RX = dm[k];
                hold(bt / 2);
                rst = 1'b0;
                m_data = 8'h00; m_rxrdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
                #1;
                chk("reset_mid_frame", {24'd0, bus.rx_data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf}, 32'd0);
                hold(5);
                bus.RX = 1'b1;
                hold(2);
                rst = 1'b1;
                hold(3);
                return;
            end
            bus.RX = dm[k];
            hold(bt);
            if (scramble && k == 2) begin
                bus.baud  = 4'($urandom_range(0, 15));
                bus.eight = 1'($urandom_range(0, 1));
                bus.pen   = 1'($urandom_range(0, 1));
                bus.ohel  = 1'($urandom_range(0, 1));
            end
        end
        bus.baud  = bcode;
        bus.eight = e8;
        bus.pen   = p_en;
        bus.ohel  = odd;
        if (p_en) begin
            bus.RX = pb;
            hold(bt);
        end
        settling = 1'b1;
        bus.RX = stopv;
        if (coinc) begin
            hold(2 + bt / 2);
            bus.rx_read = 1'b1;
            hold(1);
            bus.rx_read = 1'b0;
            hold(bt - 3 - bt / 2);
        end else begin
            hold(bt);
        end
        bus.RX  = 1'b1;
        m_ovf   = m_rxrdy && !coinc;
        m_rxrdy = 1'b1;
        m_data  = dm;
        m_perr  = p_en && (logic'((pop(dm) + int'(pb)) % 2) != odd);
        m_ferr  = !stopv;
        settling = 1'b0;
        if (!stopv) hold(2 * bt);
    endtask

    initial begin
        bus.RX = 1'b1; bus.rx_read = 1'b0;
        bus.baud = 4'hB; bus.eight = 1'b1; bus.pen = 1'b0; bus.ohel = 1'b0;
        hold(3);
        live = 1'b1;
        chk("reset_state", {24'd0, bus.rx_data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf}, 32'd0);
        rst = 1'b1;
        hold(5);

        send(8'h55, 1, 0, 0, 4'hB, 0, 1, 0, 0, -1);
        chk("8n1_data", bus.rx_data, 8'h55);
        chk("8n1_flags", {bus.rxrdy, bus.perr, bus.ferr, bus.ovf}, 4'b1000);
        do_read();
        chk("read_clears_rxrdy", bus.rxrdy, 0);
        chk("read_keeps_data", bus.rx_data, 8'h55);

        send(8'h41, 0, 1, 1, 4'hB, 1, 1, 0, 0, -1);
        chk("7o1_data", bus.rx_data, 8'h41);
        chk("7o1_perr_ferr", {bus.perr, bus.ferr}, 2'b10);
        do_read();

        send(8'hA3, 1, 0, 0, 4'hB, 0, 0, 0, 0, -1);
        chk("ferr_data", bus.rx_data, 8'hA3);
        chk("ferr_flags", {bus.rxrdy, bus.ferr}, 2'b11);
        do_read();
        send(8'h5A, 1, 0, 0, 4'hB, 0, 1, 0, 0, -1);
        chk("after_ferr", {bus.rx_data, bus.ferr}, {8'h5A, 1'b0});
        do_read();

        bus.RX = 1'b0;
        hold(30);
        bus.RX = 1'b1;
        hold(200);
        chk("glitch", {bus.rx_data, bus.rxrdy, bus.perr, bus.ferr, bus.ovf}, {8'h5A, 4'b0000});

        send(8'h12, 1, 0, 0, 4'hB, 0, 1, 0, 0, -1);
        send(8'h34, 1, 0, 0, 4'hB, 0, 1, 0, 0, -1);
        chk("overrun", {bus.rx_data, bus.rxrdy, bus.ovf}, {8'h34, 2'b11});

        send(8'hC6, 1, 0, 0, 4'hB, 0, 1, 1, 0, -1);
        chk("read_vs_complete", {bus.rx_data, bus.rxrdy, bus.ovf}, {8'hC6, 2'b10});
        do_read();

        send(8'hF0, 1, 0, 0, 4'hB, 0, 1, 0, 0, 4);
        send(8'h7E, 1, 0, 0, 4'hB, 0, 1, 0, 0, -1);
        chk("after_reset", {bus.rx_data, bus.rxrdy, bus.ovf}, {8'h7E, 2'b10});
        do_read();

        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 4'hA : 4'hB,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 5) == 0, 1'b1, -1);
            if ($urandom_range(0, 2) == 0) do_read();
            if ($urandom_range(0, 1) != 0) hold($urandom_range(1, 50));
        end

        hold(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency; the baud table in REQ-012 is valid only at this value.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 baud  input  4  baud-rate select code, decoded per REQ-012.
REQ-005 eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 pen  input  1  1 = parity bit present after data.
REQ-007 ohel  input  1  parity sense: 1 = odd, 0 = even.
REQ-008 RX  input  1  asynchronous serial line; idles high.
REQ-009 rx_read  input  1  one-cycle pulse; host consumes rx_data and status.
REQ-010 rx_data  output  8  received character, LSB-first assembly; bit 7 = 0 in 7-bit mode.
REQ-011 rxrdy, perr, ferr, ovf  output  1 each  data-ready, parity error, framing error and overrun flags.

Function
REQ-012 Bit time in clocks (BT) SHALL be: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, A:217, B:109, C-F:333333.
REQ-013 RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 baud, eight, pen, ohel SHALL be sampled on leaving IDLE and held for the whole frame; changes mid-frame have no effect until the next frame.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on synchronized RX = 0, go to START, load bit counter with BT/2 (integer division).
REQ-017 START: at counter expiry, if RX = 0, go to DATA and reload BT; if RX = 1 (glitch), return to IDLE with no flag or output change.
REQ-018 DATA: sample RX at each BT expiry (mid-bit) into the next data bit, LSB first; after 8 (eight=1) or 7 (eight=0) samples, go to PARITY if pen=1, else STOP.
REQ-019 PARITY: sample one bit at BT expiry; parity error when XOR of received data bits XOR parity bit differs from ohel (odd: total ones odd; even: total ones even).
REQ-020 STOP: sample at BT expiry; RX = 0 is a framing error; then go to IDLE regardless of the sample value.
REQ-021 On STOP sample cycle (+1 register stage) rx_data, perr and ferr SHALL update together and rxrdy SHALL be set.
REQ-022 ovf SHALL be set if a frame completes while rxrdy is still 1; rx_data is overwritten with the new character.
REQ-023 rx_read SHALL clear rxrdy, perr, ferr and ovf on the next edge; rx_data holds.
REQ-024 rx_read coincident with frame completion: completion wins; flags reflect the new frame, and ovf is not set.
REQ-025 A new start bit SHALL be accepted on the first cycle after STOP returns to IDLE (back-to-back frames, 1 stop bit).
REQ-026 Bit counter width SHALL be 19 bits (holds 333333); the bit index SHALL never exceed 8.

Reset
REQ-027 rst = 0 SHALL immediately force IDLE, counters to 0, synchronizer flops to 1, rx_data = 0x00, and rxrdy/perr/ferr/ovf = 0, including mid-frame.
REQ-028 After rst is released, the first falling RX edge SHALL begin a clean frame; a partial frame in progress at reset is discarded.

Verification
REQ-029 baud=B, eight=1, pen=0, drive 0x55 8N1 at 1085 ns/bit -> rxrdy=1, rx_data=0x55, perr=ferr=ovf=0; rx_read -> rxrdy=0.
REQ-030 baud=B, eight=0, pen=1, ohel=1, send 0x41 with parity bit 0 (wrong) -> rx_data=0x41, perr=1, ferr=0.
REQ-031 8N1, 0xA3 with stop bit driven 0 -> rxrdy=1, ferr=1, rx_data=0xA3; next frame after RX returns high receives normally.
REQ-032 RX low pulse of 300 ns at baud=B -> FSM returns to IDLE, no flag changes, rx_data unchanged.
REQ-033 Two back-to-back frames 0x12, 0x34 without rx_read -> rx_data=0x34, rxrdy=1, ovf=1.
REQ-034 rst asserted during DATA bit 4 of a frame -> all outputs 0 within the same cycle; following frame 0x7E received correctly.
